wishbone_master_if: RTL

WISHBONE_MASTER_IF -- requirements
Module: wishbone_master_if

---
 rtl/wishbone_master_if.sv | 93 +++++++++
 1 files changed

// File: rtl/wishbone_master_if.sv
// wishbone_master_if: single-outstanding Wishbone master bridging CPU accesses with ack/flush/timeout handling
module wishbone_master_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_req_o,
  output logic        err_o,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [31:0] rbuf;
  logic start, ack, tmo;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state, CPU-side outputs and transaction events
  always_comb begin
    state_nx = state;
    stall_req_o = 1'b0;
    cpu_data_o = '0;
    start = 1'b0;
    ack = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: begin
        start = cpu_ce_i & ~flush_i;
        stall_req_o = start;
        state_nx = start ? BUSY : IDLE;
      end
      BUSY: begin
        ack = wishbone_ack_i & wishbone_cyc_o & ~flush_i;
        tmo = ~flush_i & ~wishbone_ack_i & (cnt == LAST);
        stall_req_o = ~flush_i & ~wishbone_ack_i;
        cpu_data_o = (ack && !wishbone_we_o) ? wishbone_data_i : '0;
        state_nx = (flush_i || tmo) ? IDLE : ack ? (stall_i ? HOLD : IDLE) : BUSY;
      end
      HOLD: begin
        cpu_data_o = rbuf;
        state_nx = (!stall_i || flush_i) ? IDLE : HOLD;
      end
      default: state_nx = IDLE;
    endcase
  end
  // bus outputs, timeout counter, read buffer and error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_we_o <= 1'b0;
      wishbone_sel_o <= '0;
      wishbone_stb_o <= 1'b0;
      wishbone_cyc_o <= 1'b0;
      cnt <= '0;
      rbuf <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= tmo;
      if (start) begin
        wishbone_addr_o <= cpu_addr_i;
        wishbone_data_o <= cpu_data_i;
        wishbone_we_o <= cpu_we_i;
        wishbone_sel_o <= cpu_sel_i;
        wishbone_stb_o <= 1'b1;
        wishbone_cyc_o <= 1'b1;
        cnt <= '0;
      end else if (state == BUSY && state_nx != BUSY) begin
        wishbone_stb_o <= 1'b0;
        wishbone_cyc_o <= 1'b0;
      end
      if (state == BUSY && !ack && !flush_i) cnt <= cnt + 8'd1;
      if (ack) rbuf <= cpu_data_o;
    end
endmodule
